// File: rtl/soma_array.sv
`default_nettype none
// ============================================================================
// Module   : soma_array
// Purpose  : Time-multiplexed array of N_NEURON leaky integrate-and-fire
//            somas sharing one single-cycle arithmetic datapath. Each neuron
//            keeps its own potential, timestamps, DEACTIVE/ACTIVE/REFRACTORY
//            state and runtime-configurable threshold/leak/refractory/delay.
// Ports    : clk, rst (sync, active-low)
//            kill[N]            per-neuron force-to-DEACTIVE, level-sampled
//            cfg_*              per-neuron configuration write port
//            in_valid/in_ready  {in_id, in_weight, in_time} event input
//            out_valid/out_ready {out_id, out_time} spike output
//            o_wait / o_dead    per-neuron REFRACTORY / DEACTIVE flags
// Revision : 1.0 - initial release
// ============================================================================
module soma_array #(
  parameter int N_NEURON  = 4,
  parameter int W_V       = 16,
  parameter int W_W       = 8,
  parameter int W_T       = 8,
  parameter int DEF_V_TH  = 64,
  parameter int DEF_TAU   = 2,
  parameter int DEF_REFR  = 4,
  parameter int DEF_DELAY = 1,
  localparam int W_ID     = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_NEURON-1:0] kill,
  input  logic                cfg_we,
  input  logic [W_ID-1:0]     cfg_id,
  input  logic [W_V-1:0]      cfg_v_th,
  input  logic [3:0]          cfg_tau,
  input  logic [W_T-1:0]      cfg_refr,
  input  logic [W_T-1:0]      cfg_delay,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W_ID-1:0]     in_id,
  input  logic [W_W-1:0]      in_weight,
  input  logic [W_T-1:0]      in_time,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W_ID-1:0]     out_id,
  output logic [W_T-1:0]      out_time,
  output logic [N_NEURON-1:0] o_wait,
  output logic [N_NEURON-1:0] o_dead
);

  typedef enum logic [1:0] {
    ST_DEACTIVE   = 2'd0,
    ST_ACTIVE     = 2'd1,
    ST_REFRACTORY = 2'd2
  } state_t;

  localparam logic [W_T-1:0]        c_SH_MAX = W_T'(W_V - 1);
  localparam logic signed [W_V-1:0] c_V_MAX  = {1'b0, {(W_V-1){1'b1}}};
  localparam logic signed [W_V-1:0] c_V_MIN  = {1'b1, {(W_V-1){1'b0}}};

  state_t                r_state     [N_NEURON];
  state_t                w_state_nxt [N_NEURON];
  logic signed [W_V-1:0] r_v         [N_NEURON];
  logic [W_T-1:0]        r_t_last    [N_NEURON];
  logic [W_T-1:0]        r_t_fire    [N_NEURON];
  logic signed [W_V-1:0] r_v_th      [N_NEURON];
  logic [3:0]            r_tau       [N_NEURON];
  logic [W_T-1:0]        r_refr      [N_NEURON];
  logic [W_T-1:0]        r_delay     [N_NEURON];

  logic w_in_id_ok;
  logic w_cfg_id_ok;

  // Ids can only be out of range when N_NEURON is not a power of two.
  generate
    if ((1 << W_ID) == N_NEURON) begin : g_id_full
      assign w_in_id_ok  = 1'b1;
      assign w_cfg_id_ok = 1'b1;
    end else begin : g_id_chk
      localparam logic [W_ID:0] c_N = (W_ID+1)'(N_NEURON);
      assign w_in_id_ok  = ({1'b0, in_id}  < c_N);
      assign w_cfg_id_ok = ({1'b0, cfg_id} < c_N);
    end
  endgenerate

  // Shared datapath operates on the neuron addressed by the incoming event.
  state_t                w_sel_state;
  logic signed [W_V-1:0] w_sel_v, w_sel_v_th, w_base_v, w_v_dec, w_v_new;
  logic [W_T-1:0]        w_sel_t_last, w_sel_t_fire, w_sel_refr, w_sel_delay;
  logic [3:0]            w_sel_tau;
  logic [W_T-1:0]        w_since_fire, w_base_t, w_dt, w_sh_raw, w_sh;
  logic [W_V:0]          w_sum;
  logic                  w_accept, w_hit, w_refr_done, w_integ, w_fire;

  assign w_sel_state  = r_state[in_id];
  assign w_sel_v      = r_v[in_id];
  assign w_sel_t_last = r_t_last[in_id];
  assign w_sel_t_fire = r_t_fire[in_id];
  assign w_sel_v_th   = r_v_th[in_id];
  assign w_sel_tau    = r_tau[in_id];
  assign w_sel_refr   = r_refr[in_id];
  assign w_sel_delay  = r_delay[in_id];

  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A kill on the addressed neuron wins over the event.
  assign w_hit     = w_accept && w_in_id_ok && !kill[in_id];

  assign w_since_fire = in_time - w_sel_t_fire;
  assign w_refr_done  = (w_since_fire >= w_sel_refr);
  assign w_integ      = w_hit && ((w_sel_state == ST_ACTIVE) ||
                                  ((w_sel_state == ST_REFRACTORY) && w_refr_done));

  // Leaving REFRACTORY integrates from a zero potential, with the leak
  // interval measured from the firing time.
  assign w_base_v = (w_sel_state == ST_REFRACTORY) ? '0 : w_sel_v;
  assign w_base_t = (w_sel_state == ST_REFRACTORY) ? w_sel_t_fire : w_sel_t_last;
  assign w_dt     = in_time - w_base_t;
  assign w_sh_raw = w_dt >> w_sel_tau;
  assign w_sh     = (w_sh_raw > c_SH_MAX) ? c_SH_MAX : w_sh_raw;
  assign w_v_dec  = w_base_v >>> w_sh;

  // One guard bit detects overflow of the signed sum.
  assign w_sum   = {w_v_dec[W_V-1], w_v_dec} +
                   {{(W_V+1-W_W){in_weight[W_W-1]}}, in_weight};
  assign w_v_new = (w_sum[W_V] != w_sum[W_V-1]) ?
                   (w_sum[W_V] ? c_V_MIN : c_V_MAX) : w_sum[W_V-1:0];
  assign w_fire  = w_integ && (w_v_new >= w_sel_v_th);

  always_comb begin
    for (int i = 0; i < N_NEURON; i++) begin
      w_state_nxt[i] = r_state[i];
      if (kill[i]) begin
        w_state_nxt[i] = ST_DEACTIVE;
      end else if (w_hit && (in_id == W_ID'(i))) begin
        if (w_fire) begin
          w_state_nxt[i] = ST_REFRACTORY;
        end else if (w_integ) begin
          w_state_nxt[i] = ST_ACTIVE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_NEURON; i++) begin
      if (!rst) begin
        r_state[i] <= ST_ACTIVE;
        o_wait[i]  <= 1'b0;
        o_dead[i]  <= 1'b0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        o_wait[i]  <= (w_state_nxt[i] == ST_REFRACTORY);
        o_dead[i]  <= (w_state_nxt[i] == ST_DEACTIVE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_NEURON; i++) begin
        r_v[i]      <= '0;
        r_t_last[i] <= '0;
        r_t_fire[i] <= '0;
      end
    end else if (w_hit && (w_sel_state != ST_DEACTIVE)) begin
      r_t_last[in_id] <= in_time;
      if (w_integ) begin
        r_v[in_id] <= w_fire ? '0 : w_v_new;
        if (w_fire) begin
          r_t_fire[in_id] <= in_time;
        end
      end
    end
  end

  // Config registers are read by the datapath before this write lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_NEURON; i++) begin
        r_v_th[i]  <= W_V'(DEF_V_TH);
        r_tau[i]   <= 4'(DEF_TAU);
        r_refr[i]  <= W_T'(DEF_REFR);
        r_delay[i] <= W_T'(DEF_DELAY);
      end
    end else if (cfg_we && w_cfg_id_ok) begin
      r_v_th[cfg_id]  <= cfg_v_th;
      r_tau[cfg_id]   <= cfg_tau;
      r_refr[cfg_id]  <= cfg_refr;
      r_delay[cfg_id] <= cfg_delay;
    end
  end

  // Output register; a fire can only occur when it is free or draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_time  <= '0;
    end else if (w_fire) begin
      out_valid <= 1'b1;
      out_id    <= in_id;
      out_time  <= in_time + w_sel_delay;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soma_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_soma_array
// Purpose  : Self-checking bench for soma_array: directed vector table,
//            multi-cycle corner sequences and randomized traffic compared
//            against an arithmetic per-neuron reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soma_array;
  localparam int N  = 4;
  localparam int WV = 16;
  localparam int WT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] kill = '0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_id = '0;
  logic [15:0]  cfg_v_th = '0;
  logic [3:0]   cfg_tau = '0;
  logic [7:0]   cfg_refr = '0;
  logic [7:0]   cfg_delay = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_id = '0;
  logic [7:0]   in_weight = '0;
  logic [7:0]   in_time = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   out_id;
  logic [7:0]   out_time;
  logic [N-1:0] o_wait;
  logic [N-1:0] o_dead;

  soma_array dut (
    .clk(clk), .rst(rst), .kill(kill),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_v_th(cfg_v_th), .cfg_tau(cfg_tau),
    .cfg_refr(cfg_refr), .cfg_delay(cfg_delay),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_weight(in_weight), .in_time(in_time),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_time(out_time), .o_wait(o_wait), .o_dead(o_dead)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: 0 = dead, 1 = active, 2 = refractory.
  int m_v[N], m_tl[N], m_tf[N], m_st[N];
  int m_th[N], m_tau[N], m_refr[N], m_del[N];
  int m_ov, m_oid, m_ot;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_tl[i] = 0; m_tf[i] = 0; m_st[i] = 1;
      m_th[i] = 64; m_tau[i] = 2; m_refr[i] = 4; m_del[i] = 1;
    end
    m_ov = 0; m_oid = 0; m_ot = 0;
  endfunction

  // Floor division by 2^sh, i.e. arithmetic right shift.
  function automatic int fdiv(input int v, input int sh);
    int d;
    d = 1 << sh;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  // Applies one cycle to the model, then clocks the DUT and compares.
  task automatic step();
    bit acc, fired, integ;
    int n, t, w, bv, bt, dt, sh, vn, ew, ed;
    fired = 0;
    if (!rst) begin
      m_reset();
    end else begin
      acc = in_valid && (m_ov == 0 || out_ready);
      n = int'(in_id); t = int'(in_time); w = int'($signed(in_weight));
      if (acc && n < N && !kill[n]) begin
        integ = 0; bv = 0; bt = 0;
        if (m_st[n] == 1) begin
          integ = 1; bv = m_v[n]; bt = m_tl[n];
        end else if (m_st[n] == 2) begin
          if (((t - m_tf[n]) & 255) >= m_refr[n]) begin
            integ = 1; bv = 0; bt = m_tf[n];
          end else begin
            m_tl[n] = t;
          end
        end
        if (integ) begin
          dt = (t - bt) & 255;
          sh = dt >> m_tau[n];
          if (sh > WV - 1) sh = WV - 1;
          vn = fdiv(bv, sh) + w;
          if (vn > 32767) vn = 32767;
          if (vn < -32768) vn = -32768;
          m_tl[n] = t;
          if (vn >= m_th[n]) begin
            m_v[n] = 0; m_tf[n] = t; m_st[n] = 2; fired = 1;
          end else begin
            m_v[n] = vn; m_st[n] = 1;
          end
        end
      end
      if (fired) begin
        m_ov = 1; m_oid = n; m_ot = (t + m_del[n]) & 255;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (cfg_we) begin
        m_th[cfg_id]   = int'($signed(cfg_v_th));
        m_tau[cfg_id]  = int'(cfg_tau);
        m_refr[cfg_id] = int'(cfg_refr);
        m_del[cfg_id]  = int'(cfg_delay);
      end
      for (int i = 0; i < N; i++) if (kill[i]) m_st[i] = 0;
    end
    @(posedge clk);
    #1;
    ew = 0; ed = 0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 2) ew |= (1 << i);
      if (m_st[i] == 0) ed |= (1 << i);
    end
    chk("m_out_valid", int'(out_valid), m_ov);
    chk("m_in_ready", int'(in_ready), (m_ov == 0 || out_ready) ? 1 : 0);
    chk("m_o_wait", int'(o_wait), ew);
    chk("m_o_dead", int'(o_dead), ed);
    if (m_ov != 0) begin
      chk("m_out_id", int'(out_id), m_oid);
      chk("m_out_time", int'(out_time), m_ot);
    end
    in_valid = 1'b0; cfg_we = 1'b0; kill = '0;
  endtask

  task automatic ev(input int id, input int w, input int t);
    in_valid = 1'b1; in_id = 2'(id); in_weight = 8'(w); in_time = 8'(t);
  endtask

  task automatic cfg(input int id, input int th, input int tau, input int refr, input int del);
    cfg_we = 1'b1; cfg_id = 2'(id); cfg_v_th = 16'(th); cfg_tau = 4'(tau);
    cfg_refr = 8'(refr); cfg_delay = 8'(del);
  endtask

  typedef struct {
    bit v; int id; int w; int t; bit rdy;
    int exp_ov; int exp_id; int exp_t; int exp_wait;
  } vec_t;

  vec_t tbl[13];
  int   rt;

  initial begin
    // Integrate/fire, leak with clamp, refractory, backpressure.
    tbl[0]  = '{1, 0,  40,  0, 1, 0, 0,  0, 1'b0};
    tbl[1]  = '{1, 0,  40,  1, 1, 1, 0,  2, 1};
    tbl[2]  = '{1, 0,  40,  2, 1, 0, 0,  0, 1};
    tbl[3]  = '{1, 1,  60,  0, 1, 0, 0,  0, 1};
    tbl[4]  = '{1, 1,  10,  8, 1, 0, 0,  0, 1};
    tbl[5]  = '{1, 1,   0,  7, 1, 0, 0,  0, 1};
    tbl[6]  = '{1, 1,  63,  7, 1, 0, 0,  0, 1};
    tbl[7]  = '{1, 0, 100, 10, 1, 1, 0, 11, 1};
    tbl[8]  = '{1, 0, 100, 12, 1, 0, 0,  0, 1};
    tbl[9]  = '{1, 0, 100, 14, 1, 1, 0, 15, 1};
    tbl[10] = '{0, 0,   0,  0, 0, 1, 0, 15, 1};
    tbl[11] = '{1, 2, 100, 20, 0, 1, 0, 15, 1};
    tbl[12] = '{0, 0,   0,  0, 1, 0, 0,  0, 1};

    m_reset();
    rst = 1'b0;
    step();
    step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_time", int'(out_time), 0);
    chk("rst_o_wait", int'(o_wait), 0);
    chk("rst_o_dead", int'(o_dead), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].v) ev(tbl[i].id, tbl[i].w, tbl[i].t);
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), tbl[i].exp_ov);
      if (tbl[i].exp_ov != 0) begin
        chk($sformatf("tbl%0d_out_id", i), int'(out_id), tbl[i].exp_id);
        chk($sformatf("tbl%0d_out_time", i), int'(out_time), tbl[i].exp_t);
      end
      chk($sformatf("tbl%0d_o_wait", i), int'(o_wait), tbl[i].exp_wait);
    end

    // Refractory across timestamp wrap: fire at 250, refr 10.
    out_ready = 1'b1;
    cfg(0, 64, 2, 10, 1); step();
    ev(0, 100, 250); step();
    chk("wrap_fire_valid", int'(out_valid), 1);
    chk("wrap_fire_time", int'(out_time), 251);
    ev(0, 100, 3); step();
    chk("wrap_drop_valid", int'(out_valid), 0);
    ev(0, 100, 4); step();
    chk("wrap_refire_valid", int'(out_valid), 1);
    chk("wrap_refire_time", int'(out_time), 5);

    // Saturation: 258*127 stays below 32767, the 259th saturates and fires.
    cfg(3, 32767, 2, 4, 1); step();
    for (int k = 0; k < 259; k++) begin
      ev(3, 127, 50); step();
      if (k == 257) chk("sat_no_fire_258", int'(out_valid), 0);
    end
    chk("sat_fire_valid", int'(out_valid), 1);
    chk("sat_fire_id", int'(out_id), 3);
    chk("sat_fire_time", int'(out_time), 51);

    // Config write coincident with an event: old threshold applies.
    cfg(3, 64, 2, 4, 1); step();
    cfg(3, 10, 2, 4, 1); ev(3, 20, 60); step();
    chk("cfg_same_cycle_valid", int'(out_valid), 0);
    ev(3, 0, 60); step();
    chk("cfg_next_fire_valid", int'(out_valid), 1);
    chk("cfg_next_fire_time", int'(out_time), 61);

    // Kill beats a firing event.
    kill = 4'b0100; ev(2, 100, 70); step();
    chk("kill_no_spike", int'(out_valid), 0);
    chk("kill_dead", int'(o_dead[2]), 1);
    ev(2, 100, 80); step();
    chk("kill_ignored", int'(out_valid), 0);

    // Reset while a spike is pending.
    ev(1, 100, 90); step();
    chk("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b0; out_ready = 1'b0; step();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_id", int'(out_id), 0);
    chk("midrst_out_time", int'(out_time), 0);
    chk("midrst_o_wait", int'(o_wait), 0);
    chk("midrst_o_dead", int'(o_dead), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst = 1'b1;

    // Random traffic against the model.
    rt = 0;
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        ev(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : (c / 50) % N,
           int'($urandom_range(0, 200)) - 70, rt);
      rt = (rt + int'($urandom_range(0, 6))) & 255;
      if ($urandom_range(0, 15) == 0)
        cfg($urandom_range(0, 3), int'($urandom_range(0, 150)) - 20,
            $urandom_range(0, 4), $urandom_range(0, 12), $urandom_range(0, 10));
      if ($urandom_range(0, 149) == 0) kill = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
